cmd_stream_tx: RTL and testbench

//  Host-side transmitter for the graphite command stream; it drives the AXI-stream slave port cmd_axis_*.

---
 rtl/cmd_stream_pkg.sv | 14 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/cmd_stream_tx.sv | 147 ++++++++++++++
 tb/tb_cmd_stream_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_stream_pkg.sv
// Shared definitions for the graphite command-stream transmitter.
//   state_t  : serializer FSM states
//   HI_FIRST : beat order of a command word on the stream (upper half first)
package cmd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

  localparam bit HI_FIRST = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with show-ahead read port.
// Ports:
//   clk, reset_i      : clock, asynchronous active-high reset
//   wr_en, wr_data    : write strobe/data; ignored while full
//   rd_en, rd_data    : pop strobe; rd_data shows the head entry before the pop
//   full, empty       : occupancy flags, decoded from the registered count
//   level             : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;

endmodule

// File: rtl/cmd_stream_tx.sv
// Host-side transmitter for the graphite command stream.
// Host words are queued in a FIFO and each word is sent as two beats,
// upper half first, on an AXI-stream master.
// Ports:
//   clk, reset_i        : clock, asynchronous active-high reset
//   wr_en_i, wr_data_i  : host write strobe and command word
//   full_o, empty_o     : FIFO flags (holding register excluded from empty_o)
//   level_o             : FIFO occupancy in words
//   busy_o              : FIFO non-empty or a word is being serialized
//   overflow_o          : sticky dropped-write flag, cleared by clr_overflow_i
//   cmd_axis_*          : AXI-stream master towards graphite
// WORD_WIDTH must equal 2*CMD_STREAM_WIDTH; FIFO_DEPTH a power of two, >= 2.
//
// state   | meaning
// IDLE    | nothing on the stream, waiting for a queued word
// SEND_HI | first half of the held word presented
// SEND_LO | second half presented; next word may be chained without a bubble
module cmd_stream_tx
  import cmd_stream_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 16,
  parameter int WORD_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          wr_en_i,
  input  logic [WORD_WIDTH-1:0]         wr_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  input  logic                          clr_overflow_i,
  output logic                          cmd_axis_tvalid_o,
  input  logic                          cmd_axis_tready_i,
  output logic [CMD_STREAM_WIDTH-1:0]   cmd_axis_tdata_o
);

  localparam int SW = CMD_STREAM_WIDTH;

  logic [WORD_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  state_t                state, state_nxt;
  logic [SW-1:0]         hold, hold_nxt;
  logic [SW-1:0]         tdata, tdata_nxt;
  logic                  tvalid, tvalid_nxt;
  logic [SW-1:0]         head_first;
  logic [SW-1:0]         head_second;

  sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .wr_en   (wr_en_i),
    .wr_data (wr_data_i),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  // Split the head word into stream order; only the second half needs holding
  // because the first half goes straight into the output register.
  assign head_first  = HI_FIRST ? fifo_rd_data[WORD_WIDTH-1 -: SW] : fifo_rd_data[SW-1:0];
  assign head_second = HI_FIRST ? fifo_rd_data[SW-1:0] : fifo_rd_data[WORD_WIDTH-1 -: SW];

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      hold   <= '0;
      tdata  <= '0;
      tvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      tdata  <= tdata_nxt;
      tvalid <= tvalid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    tdata_nxt  = tdata;
    tvalid_nxt = tvalid;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          hold_nxt   = head_second;
          tdata_nxt  = head_first;
          tvalid_nxt = 1'b1;
          state_nxt  = SEND_HI;
        end
      end
      SEND_HI: begin
        if (cmd_axis_tready_i) begin
          tdata_nxt = hold;
          state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        if (cmd_axis_tready_i) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            hold_nxt  = head_second;
            tdata_nxt = head_first;
            state_nxt = SEND_HI;
          end else begin
            tvalid_nxt = 1'b0;
            state_nxt  = IDLE;
          end
        end
      end
      default: begin
        tvalid_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // A dropped write wins over a same-cycle clear so no drop goes unreported.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
    end else if (wr_en_i && fifo_full) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  assign full_o            = fifo_full;
  assign empty_o           = fifo_empty;
  assign busy_o            = !fifo_empty || (state != IDLE);
  assign cmd_axis_tvalid_o = tvalid;
  assign cmd_axis_tdata_o  = tdata;

endmodule

// File: tb/tb_cmd_stream_tx.sv
module tb_cmd_stream_tx;

  localparam int SW = 16;
  localparam int WW = 32;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [WW-1:0] wr_data_i = '0;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          busy_o;
  logic          overflow_o;
  logic          clr_overflow_i = 1'b0;
  logic          cmd_axis_tvalid_o;
  logic          cmd_axis_tready_i = 1'b0;
  logic [SW-1:0] cmd_axis_tdata_o;

  cmd_stream_tx #(
    .CMD_STREAM_WIDTH (SW),
    .WORD_WIDTH       (WW),
    .FIFO_DEPTH       (D)
  ) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .wr_en_i           (wr_en_i),
    .wr_data_i         (wr_data_i),
    .full_o            (full_o),
    .empty_o           (empty_o),
    .level_o           (level_o),
    .busy_o            (busy_o),
    .overflow_o        (overflow_o),
    .clr_overflow_i    (clr_overflow_i),
    .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
    .cmd_axis_tready_i (cmd_axis_tready_i),
    .cmd_axis_tdata_o  (cmd_axis_tdata_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int beat_cnt = 0;
  int cyc_cnt  = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc  = 0;

  // Reference model: every accepted word becomes two beats, upper half first,
  // delivered in write order.
  logic [SW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, evaluate the handshake that
  // the next rising edge will see, then advance to the next falling edge.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic rdy, input logic acc);
    logic [SW-1:0] e;
    wr_en_i           = wr;
    wr_data_i         = d;
    cmd_axis_tready_i = rdy;
    #1;
    if (cmd_axis_tvalid_o && rdy) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_beat observed=0x%0h expected=no_beat", cmd_axis_tdata_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", {16'h0, cmd_axis_tdata_o}, {16'h0, e});
      end
      if (beat_cnt == 0) first_beat_cyc = cyc_cnt;
      last_beat_cyc = cyc_cnt;
      beat_cnt++;
    end
    if (wr && acc) begin
      exp_q.push_back(d[31:16]);
      exp_q.push_back(d[15:0]);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_cnt++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_axis_tvalid_o) && n < 400) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    n_assert++;
    assert (exp_q.size() == 0 && !cmd_axis_tvalid_o) else begin
      n_fail++;
      $error("FAIL %s_drain observed=%0d beats outstanding expected=0", tag, exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset_i           = 1'b1;
    wr_en_i           = 1'b0;
    wr_data_i         = '0;
    cmd_axis_tready_i = 1'b0;
    clr_overflow_i    = 1'b0;
    exp_q.delete();
    beat_cnt = 0;
    cyc_cnt  = 0;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    int   sent;
    int   n;
    logic w;

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_tvalid",   cmd_axis_tvalid_o, 0);
    chk("rst_tdata",    cmd_axis_tdata_o,  0);
    chk("rst_full",     full_o,            0);
    chk("rst_empty",    empty_o,           1);
    chk("rst_level",    level_o,           0);
    chk("rst_busy",     busy_o,            0);
    chk("rst_overflow", overflow_o,        0);
    do_reset();

    // 1. Single word
    cyc(1'b1, 32'h1234ABCD, 1'b1, 1'b1);
    chk("t1_latency_tvalid", cmd_axis_tvalid_o, 0);
    chk("t1_busy_queued",    busy_o,            1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t1_tvalid", cmd_axis_tvalid_o, 1);
    chk("t1_hi",     cmd_axis_tdata_o,  32'h1234);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t1_lo", cmd_axis_tdata_o, 32'hABCD);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t1_tvalid_end", cmd_axis_tvalid_o, 0);
    chk("t1_busy_end",   busy_o,            0);
    chk("t1_beats",      beat_cnt,          2);

    // 2. Backpressure
    do_reset();
    cyc(1'b1, 32'h1234ABCD, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_tvalid", cmd_axis_tvalid_o, 1);
      chk("t2_hold_tdata",  cmd_axis_tdata_o,  32'h1234);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    drain("t2");
    chk("t2_beats", beat_cnt, 2);

    // 3. Fill and overflow
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 32'h00010000 + i, 1'b0, 1'b1);
    chk("t3_full",     full_o,     1);
    chk("t3_level",    level_o,    16);
    chk("t3_overflow_pre", overflow_o, 0);
    cyc(1'b1, 32'h00010011, 1'b0, 1'b0);
    chk("t3_overflow", overflow_o, 1);
    chk("t3_level_after_drop", level_o, 16);
    clr_overflow_i = 1'b1;
    cyc(1'b1, 32'h00010012, 1'b0, 1'b0);
    clr_overflow_i = 1'b0;
    chk("t3_clr_vs_drop", overflow_o, 1);
    clr_overflow_i = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    clr_overflow_i = 1'b0;
    chk("t3_clr", overflow_o, 0);
    drain("t3");
    chk("t3_beats", beat_cnt, 34);
    chk("t3_empty_end", empty_o, 1);

    // 4. Back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0000000 + (i << 16) + 32'h0000B000 + i, 1'b1, 1'b1);
    drain("t4");
    chk("t4_beats",      beat_cnt,                       8);
    chk("t4_contiguous", last_beat_cyc - first_beat_cyc, 7);

    // 5. Reset mid-word
    do_reset();
    cyc(1'b1, 32'h11112222, 1'b1, 1'b1);
    cyc(1'b1, 32'h33334444, 1'b1, 1'b1);
    n = 0;
    while (beat_cnt < 1 && n < 10) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("t5_hi_accepted", beat_cnt, 1);
    reset_i = 1'b1;
    #1;
    chk("t5_rst_tvalid", cmd_axis_tvalid_o, 0);
    chk("t5_rst_empty",  empty_o,           1);
    chk("t5_rst_level",  level_o,           0);
    chk("t5_rst_busy",   busy_o,            0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_quiet_after_rst", cmd_axis_tvalid_o, 0);
    cyc(1'b1, 32'hCAFE0001, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_new_tvalid", cmd_axis_tvalid_o, 1);
    chk("t5_new_hi",     cmd_axis_tdata_o,  32'hCAFE);
    drain("t5");

    // 6. Random traffic with a writer that honours full_o
    do_reset();
    sent = 0;
    n    = 0;
    while (sent < 200 && n < 5000) begin
      w = ($urandom_range(0, 1) == 1) && !full_o;
      cyc(w, $urandom, ($urandom_range(0, 3) != 0), 1'b1);
      if (w) sent++;
      n++;
    end
    chk("t6_words_sent", sent, 200);
    drain("t6");
    chk("t6_beats",    beat_cnt,   400);
    chk("t6_overflow", overflow_o, 0);
    chk("t6_busy_end", busy_o,     0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
